// File: rtl/ysyx_23060075_gpr_ctrl_pkg.sv
// Shared constants for the GPR write-port controller: ISA widths and
// writeback source encodings used by the round-robin pointer.
package ysyx_23060075_gpr_ctrl_pkg;

    localparam int ysyx_23060075_REG_ADDR_WIDTH = 5;
    localparam int ysyx_23060075_ISA_WIDTH      = 32;
    localparam int ysyx_23060075_CNT_WIDTH      = 4;

    localparam logic ysyx_23060075_WB_SRC_EXU = 1'b0;
    localparam logic ysyx_23060075_WB_SRC_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060075_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the loser only
// after a contended grant so a lone requester never disturbs fairness.
module ysyx_23060075_rr_arb2
    import ysyx_23060075_gpr_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic       rr_r;
    logic [1:0] gnt_s;

    // grant selection
    always_comb begin
        gnt_s = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (rr_r == ysyx_23060075_WB_SRC_EXU) ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    // priority pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r <= ysyx_23060075_WB_SRC_EXU;
        end else if (en && (req == 2'b11)) begin
            rr_r <= ~rr_r;
        end else begin
            rr_r <= rr_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/ysyx_23060075_gpr_ctrl.sv
// GPR scoreboard and write-port scheduler: stalls issue on hazards against
// in-flight writes and funnels EXU/LSU writebacks onto the single GPR port.
module ysyx_23060075_gpr_ctrl
    import ysyx_23060075_gpr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = ysyx_23060075_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH   = ysyx_23060075_ISA_WIDTH,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [ADDR_WIDTH-1:0]     issue_rs1_addr,
    input  logic [ADDR_WIDTH-1:0]     issue_rs2_addr,
    input  logic [ADDR_WIDTH-1:0]     issue_rd_addr,
    input  logic                      issue_rd_wen,
    input  logic                      exu_wb_valid,
    output logic                      exu_wb_ready,
    input  logic [ADDR_WIDTH-1:0]     exu_wb_addr,
    input  logic [DATA_WIDTH-1:0]     exu_wb_data,
    input  logic                      lsu_wb_valid,
    output logic                      lsu_wb_ready,
    input  logic [ADDR_WIDTH-1:0]     lsu_wb_addr,
    input  logic [DATA_WIDTH-1:0]     lsu_wb_data,
    input  logic                      flush,
    output logic [DATA_WIDTH-1:0]     gpr_w,
    output logic [ADDR_WIDTH-1:0]     gpr_w_addr,
    output logic                      gpr_w_en,
    output logic                      sb_err,
    output logic [(1<<ADDR_WIDTH)-1:0] busy_vec
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam int CNT_W = ysyx_23060075_CNT_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [NREGS-1:0]      busy_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  sb_err_r;

    logic [1:0]            gnt_s;
    logic                  arb_en_s;
    logic                  wb_fire_s;
    logic [ADDR_WIDTH-1:0] wb_addr_s;
    logic [DATA_WIDTH-1:0] wb_data_s;
    logic                  wb_nz_s;
    logic                  wb_clr_s;
    logic                  wb_err_s;
    logic                  issue_ready_s;
    logic                  issue_fire_s;
    logic [NREGS-1:0]      busy_set_s;
    logic [NREGS-1:0]      busy_clr_s;
    logic [NREGS-1:0]      busy_nxt_s;
    logic [CNT_W-1:0]      cnt_nxt_s;

    assign arb_en_s = !rst && !flush;

    ysyx_23060075_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({lsu_wb_valid, exu_wb_valid}),
        .en  (arb_en_s),
        .gnt (gnt_s)
    );

    // hazard check against registered busy bits only
    always_comb begin
        issue_ready_s = 1'b0;
        if (!rst && !flush) begin
            issue_ready_s = !busy_r[issue_rs1_addr]
                         && !busy_r[issue_rs2_addr]
                         && !(issue_rd_wen && busy_r[issue_rd_addr])
                         && !(issue_rd_wen && (issue_rd_addr != '0) && (cnt_r == CNT_MAX));
        end else begin
            issue_ready_s = 1'b0;
        end
    end

    assign issue_fire_s = issue_valid && issue_ready_s && issue_rd_wen && (issue_rd_addr != '0);

    // write-port mux of the granted requester
    always_comb begin
        wb_addr_s = '0;
        wb_data_s = '0;
        case (gnt_s)
            2'b01: begin
                wb_addr_s = exu_wb_addr;
                wb_data_s = exu_wb_data;
            end
            2'b10: begin
                wb_addr_s = lsu_wb_addr;
                wb_data_s = lsu_wb_data;
            end
            default: begin
                wb_addr_s = '0;
                wb_data_s = '0;
            end
        endcase
    end

    assign wb_fire_s = |gnt_s;
    assign wb_nz_s   = wb_fire_s && (wb_addr_s != '0);
    assign wb_clr_s  = wb_nz_s && busy_r[wb_addr_s];
    assign wb_err_s  = wb_nz_s && !busy_r[wb_addr_s];

    // next busy vector; set and clear never collide since rd must be idle to issue
    always_comb begin
        busy_set_s = '0;
        busy_clr_s = '0;
        if (issue_fire_s) begin
            busy_set_s[issue_rd_addr] = 1'b1;
        end else begin
            busy_set_s = '0;
        end
        if (wb_clr_s) begin
            busy_clr_s[wb_addr_s] = 1'b1;
        end else begin
            busy_clr_s = '0;
        end
        busy_nxt_s    = (busy_r | busy_set_s) & ~busy_clr_s;
        busy_nxt_s[0] = 1'b0;
    end

    // in-flight counter update
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({issue_fire_s, wb_clr_s})
            2'b10:   cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // scoreboard state; flush clears bookkeeping but keeps the sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= '0;
            cnt_r    <= '0;
            sb_err_r <= 1'b0;
        end else if (flush) begin
            busy_r   <= '0;
            cnt_r    <= '0;
            sb_err_r <= sb_err_r;
        end else begin
            busy_r   <= busy_nxt_s;
            cnt_r    <= cnt_nxt_s;
            sb_err_r <= sb_err_r | wb_err_s;
        end
    end

    assign issue_ready  = issue_ready_s;
    assign exu_wb_ready = gnt_s[0];
    assign lsu_wb_ready = gnt_s[1];
    assign gpr_w        = wb_data_s;
    assign gpr_w_addr   = wb_addr_s;
    assign gpr_w_en     = wb_nz_s;
    assign sb_err       = sb_err_r;
    assign busy_vec     = busy_r;

endmodule

// File: tb/tb_ysyx_23060075_gpr_ctrl.sv
// Scoreboard bench: stimulus queues expected writebacks and per-cycle probes,
// a negedge monitor pops and compares them against the DUT.
module tb_ysyx_23060075_gpr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, issue_rd_wen;
    logic [4:0]  issue_rs1_addr, issue_rs2_addr, issue_rd_addr;
    logic        exu_wb_valid, exu_wb_ready, lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  exu_wb_addr, lsu_wb_addr, gpr_w_addr;
    logic [31:0] exu_wb_data, lsu_wb_data, gpr_w, busy_vec;
    logic        flush, gpr_w_en, sb_err;

    ysyx_23060075_gpr_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1_addr(issue_rs1_addr), .issue_rs2_addr(issue_rs2_addr),
        .issue_rd_addr(issue_rd_addr), .issue_rd_wen(issue_rd_wen),
        .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready),
        .exu_wb_addr(exu_wb_addr), .exu_wb_data(exu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .flush(flush), .gpr_w(gpr_w), .gpr_w_addr(gpr_w_addr),
        .gpr_w_en(gpr_w_en), .sb_err(sb_err), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    localparam int K_IRDY = 0, K_EXRDY = 1, K_LSRDY = 2, K_GWEN = 3, K_BUSY = 4,
                   K_CNT = 5, K_RR = 6, K_SBERR = 7, K_GW = 8;

    typedef struct { int cyc; int kind; logic [31:0] exp; } probe_t;
    typedef struct { int src; logic [4:0] addr; logic [31:0] data; logic en; } wb_t;

    probe_t probe_q[$];
    wb_t    wb_q[$];
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    logic   done_req = 1'b0;
    logic   done_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_IRDY:  return "issue_ready";
            K_EXRDY: return "exu_wb_ready";
            K_LSRDY: return "lsu_wb_ready";
            K_GWEN:  return "gpr_w_en";
            K_BUSY:  return "busy_vec";
            K_CNT:   return "cnt";
            K_RR:    return "rr";
            K_SBERR: return "sb_err";
            K_GW:    return "gpr_w";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] sample(int k);
        case (k)
            K_IRDY:  return {31'd0, issue_ready};
            K_EXRDY: return {31'd0, exu_wb_ready};
            K_LSRDY: return {31'd0, lsu_wb_ready};
            K_GWEN:  return {31'd0, gpr_w_en};
            K_BUSY:  return busy_vec;
            K_CNT:   return {28'd0, dut.cnt_r};
            K_RR:    return {31'd0, dut.u_arb.rr_r};
            K_SBERR: return {31'd0, sb_err};
            K_GW:    return gpr_w;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // monitor: compares due probes and every writeback handshake
    always @(negedge clk) begin
        probe_t p;
        wb_t    w;
        logic [31:0] act;
        int     asrc;
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            act = sample(p.kind);
            total++;
            if (p.cyc != cyc || act !== p.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", kname(p.kind), p.cyc, act, p.exp);
            end
        end
        if (exu_wb_ready || lsu_wb_ready) begin
            total++;
            asrc = exu_wb_ready ? 0 : 1;
            if (wb_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected cyc=%0d got src=%0d addr=%0d data=%h expected none",
                         cyc, asrc, gpr_w_addr, gpr_w);
            end else begin
                w = wb_q.pop_front();
                if ((exu_wb_ready && lsu_wb_ready) || asrc != w.src || gpr_w_addr !== w.addr ||
                    gpr_w !== w.data || gpr_w_en !== w.en) begin
                    bad++;
                    $display("FAIL wb cyc=%0d got src=%0d addr=%0d data=%h en=%b expected src=%0d addr=%0d data=%h en=%b",
                             cyc, asrc, gpr_w_addr, gpr_w, gpr_w_en, w.src, w.addr, w.data, w.en);
                end
            end
        end
        if (done_req && !done_ack) begin
            total++;
            if (wb_q.size() != 0 || probe_q.size() != 0) begin
                bad++;
                $display("FAIL leftover got wb=%0d probes=%0d expected 0", wb_q.size(), probe_q.size());
            end
            done_ack = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(int k, logic [31:0] e);
        probe_t p;
        p.cyc = cyc; p.kind = k; p.exp = e;
        probe_q.push_back(p);
    endtask

    task automatic expect_wb(int src, logic [4:0] a, logic [31:0] d, logic en);
        wb_t w;
        w.src = src; w.addr = a; w.data = d; w.en = en;
        wb_q.push_back(w);
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd_wen = 1'b0;
        issue_rs1_addr = 5'd0; issue_rs2_addr = 5'd0; issue_rd_addr = 5'd0;
        exu_wb_valid = 1'b0; exu_wb_addr = 5'd0; exu_wb_data = 32'd0;
        lsu_wb_valid = 1'b0; lsu_wb_addr = 5'd0; lsu_wb_data = 32'd0;
        flush = 1'b0;
    endtask

    task automatic issue_w(logic [4:0] rd);
        idle();
        issue_valid = 1'b1; issue_rd_wen = 1'b1; issue_rd_addr = rd;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // reset: everything held off even with requests present
        step();
        issue_w(5'd1); exu_wb_valid = 1'b1; lsu_wb_valid = 1'b1;
        probe(K_IRDY, 32'd0); probe(K_EXRDY, 32'd0); probe(K_LSRDY, 32'd0); probe(K_GWEN, 32'd0);
        step();
        rst = 1'b0; idle();
        probe(K_BUSY, 32'd0); probe(K_CNT, 32'd0); probe(K_RR, 32'd0);
        probe(K_SBERR, 32'd0); probe(K_GW, 32'd0); probe(K_GWEN, 32'd0);

        // RAW stall and writeback release
        step(); issue_w(5'd5); probe(K_IRDY, 32'd1);
        step(); idle(); issue_valid = 1'b1; issue_rs1_addr = 5'd5;
        probe(K_IRDY, 32'd0); probe(K_BUSY, 32'h20); probe(K_CNT, 32'd1);
        step(); probe(K_IRDY, 32'd0);
        step(); exu_wb_valid = 1'b1; exu_wb_addr = 5'd5; exu_wb_data = 32'hDEAD;
        expect_wb(0, 5'd5, 32'hDEAD, 1'b1); probe(K_IRDY, 32'd0);
        step(); exu_wb_valid = 1'b0;
        probe(K_IRDY, 32'd1); probe(K_BUSY, 32'd0); probe(K_CNT, 32'd0);

        // contention: alternating grants, then a lone x0 writeback
        for (int r = 1; r <= 4; r++) begin
            step(); issue_w(5'(r)); probe(K_IRDY, 32'd1);
        end
        step(); idle();
        exu_wb_valid = 1'b1; exu_wb_addr = 5'd1; exu_wb_data = 32'h11;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd2; lsu_wb_data = 32'h22;
        probe(K_CNT, 32'd4); expect_wb(0, 5'd1, 32'h11, 1'b1);
        step(); exu_wb_addr = 5'd3; exu_wb_data = 32'h33; expect_wb(1, 5'd2, 32'h22, 1'b1);
        step(); lsu_wb_addr = 5'd4; lsu_wb_data = 32'h44; expect_wb(0, 5'd3, 32'h33, 1'b1);
        step(); exu_wb_addr = 5'd0; exu_wb_data = 32'h55; expect_wb(1, 5'd4, 32'h44, 1'b1);
        step(); lsu_wb_valid = 1'b0; expect_wb(0, 5'd0, 32'h55, 1'b0);
        probe(K_RR, 32'd0); probe(K_EXRDY, 32'd1); probe(K_GWEN, 32'd0);
        step(); idle();
        probe(K_BUSY, 32'd0); probe(K_CNT, 32'd0); probe(K_SBERR, 32'd0); probe(K_GW, 32'd0);

        // x0 issue leaves the scoreboard alone
        step(); issue_w(5'd0); probe(K_IRDY, 32'd1);
        step(); idle(); probe(K_BUSY, 32'd0); probe(K_CNT, 32'd0);

        // in-flight limit with a same-cycle clear
        for (int r = 1; r <= 4; r++) begin
            step(); issue_w(5'(r));
        end
        step(); issue_w(5'd6); probe(K_IRDY, 32'd0); probe(K_CNT, 32'd4);
        step(); exu_wb_valid = 1'b1; exu_wb_addr = 5'd2; exu_wb_data = 32'h2222;
        expect_wb(0, 5'd2, 32'h2222, 1'b1); probe(K_IRDY, 32'd0);
        step(); issue_w(5'd6); probe(K_IRDY, 32'd1); probe(K_CNT, 32'd3); probe(K_BUSY, 32'h1A);
        step(); issue_w(5'd9); flush = 1'b1;
        probe(K_CNT, 32'd4); probe(K_BUSY, 32'h5A); probe(K_IRDY, 32'd0);

        // flush with a pending LSU writeback
        step(); issue_w(5'd7); probe(K_BUSY, 32'd0); probe(K_CNT, 32'd0); probe(K_IRDY, 32'd1);
        step(); issue_w(5'd8);
        step(); issue_w(5'd9);
        step(); idle();
        exu_wb_valid = 1'b1; exu_wb_addr = 5'd9; exu_wb_data = 32'h99;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd7; lsu_wb_data = 32'h77;
        expect_wb(0, 5'd9, 32'h99, 1'b1);
        step(); exu_wb_valid = 1'b0; flush = 1'b1;
        probe(K_LSRDY, 32'd0); probe(K_GWEN, 32'd0); probe(K_BUSY, 32'h180); probe(K_CNT, 32'd2);
        step(); flush = 1'b0; expect_wb(1, 5'd7, 32'h77, 1'b1);
        probe(K_LSRDY, 32'd1); probe(K_BUSY, 32'd0); probe(K_CNT, 32'd0);
        probe(K_RR, 32'd1); probe(K_SBERR, 32'd0);
        step(); idle(); probe(K_SBERR, 32'd1); probe(K_CNT, 32'd0); probe(K_BUSY, 32'd0);

        // mid-operation reset
        for (int r = 1; r <= 3; r++) begin
            step(); issue_w(5'(r));
        end
        step(); issue_w(5'd4); rst = 1'b1;
        exu_wb_valid = 1'b1; exu_wb_addr = 5'd1; exu_wb_data = 32'hA1;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd2; lsu_wb_data = 32'hA2;
        probe(K_EXRDY, 32'd0); probe(K_LSRDY, 32'd0); probe(K_IRDY, 32'd0); probe(K_GWEN, 32'd0);
        probe(K_CNT, 32'd3); probe(K_SBERR, 32'd1); probe(K_RR, 32'd1);
        step(); rst = 1'b0; idle();
        probe(K_BUSY, 32'd0); probe(K_CNT, 32'd0); probe(K_RR, 32'd0); probe(K_SBERR, 32'd0);

        step(); step();
        done_req = 1'b1;
        for (int i = 0; i < 20 && !done_ack; i++) @(posedge clk);
        if (!done_ack) begin
            $display("FAIL monitor_timeout got no ack expected ack");
            $fatal(1, "monitor did not complete");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
